// File: rtl/apb_cmd_master_if.sv
// APB3 bus bundle between a fabric-side initiator and its slave(s).
// master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples PRDATA/PREADY/PSLVERR.
// slave modport : the mirror image.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Fabric-side APB3 initiator. Converts single-beat fabric commands into APB3
// transfers and optionally auto-polls one read address at a fixed period.
// Ports:
//   PCLK, PRESERN          clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid              one-cycle completion pulse; rsp_rdata/rsp_err/rsp_timeout/rsp_poll
//   poll_en, poll_addr     auto-poll control; poll_data = last error-free poll read
//   apb                    APB3 master side of the bus
module apb_cmd_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned POLL_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              rsp_poll,
  input  logic              poll_en,
  input  logic [ADDR_W-1:0] poll_addr,
  output logic [DATA_W-1:0] poll_data,
  apb_cmd_master_if.master  apb
);

  localparam int unsigned PCNT_W = (POLL_PERIOD < 2) ? 1 : $clog2(POLL_PERIOD);
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              poll;
  } xfer_t;

  state_t              state_q,     state_d;
  xfer_t               xfer_q,      xfer_d;
  logic [WAIT_W-1:0]   wait_q,      wait_d;
  logic [PCNT_W-1:0]   poll_cnt_q,  poll_cnt_d;
  logic                poll_pend_q, poll_pend_d;
  logic                psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                ready_q,     ready_d;
  logic                rvalid_q,    rvalid_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                err_q,       err_d;
  logic                to_q,        to_d;
  logic                rpoll_q,     rpoll_d;
  logic [DATA_W-1:0]   pdata_q,     pdata_d;
  logic                take_poll;
  logic                poll_expire;

  // State/output registers; reset clears everything, dropping PSEL/PENABLE immediately.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q     <= IDLE;
      xfer_q      <= '0;
      wait_q      <= '0;
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      rpoll_q     <= 1'b0;
      pdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      wait_q      <= wait_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_pend_q <= poll_pend_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      to_q        <= to_d;
      rpoll_q     <= rpoll_d;
      pdata_q     <= pdata_d;
    end
  end

  // Next-state, transfer capture, poll timer and registered-output decode.
  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    to_d        = to_q;
    rpoll_d     = rpoll_q;
    pdata_d     = pdata_q;
    poll_cnt_d  = '0;
    poll_pend_d = 1'b0;
    take_poll   = 1'b0;
    poll_expire = poll_en && (poll_cnt_q == PCNT_W'(POLL_PERIOD - 1));

    case (state_q)
      IDLE: begin
        // A pending poll has priority; cmd_ready is already low while it is pending.
        if (poll_pend_q) begin
          xfer_d.addr  = poll_addr;
          xfer_d.write = 1'b0;
          xfer_d.poll  = 1'b1;
          take_poll    = 1'b1;
          state_d      = SETUP;
        end else if (cmd_valid && ready_q) begin
          xfer_d  = '{addr: cmd_addr, wdata: cmd_wdata, write: cmd_write, poll: 1'b0};
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          rdata_d = xfer_q.write ? '0 : apb.PRDATA;
          err_d   = apb.PSLVERR;
          to_d    = 1'b0;
          rpoll_d = xfer_q.poll;
          if (xfer_q.poll && !xfer_q.write && !apb.PSLVERR) begin
            pdata_d = apb.PRDATA;
          end
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1))) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          rpoll_d = xfer_q.poll;
          state_d = RESP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky poll request: a new expiry wins over the clear from launching a poll.
    if (poll_en) begin
      poll_cnt_d  = poll_expire ? '0 : poll_cnt_q + PCNT_W'(1);
      poll_pend_d = poll_expire || (poll_pend_q && !take_poll);
    end

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
    ready_d   = (state_d == IDLE) && !poll_pend_d;
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign rsp_poll    = rpoll_q;
  assign poll_data   = pdata_q;

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = xfer_q.write;
  assign apb.PADDR   = xfer_q.addr;
  assign apb.PWDATA  = xfer_q.wdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: random commands against a reference
// memory model, an APB slave model with planned wait states/errors, and a
// response scoreboard, plus directed latency, timeout, poll and reset checks.
module tb_apb_cmd_master;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned POLL_PERIOD = 8;
  localparam int unsigned TIMEOUT     = 4;
  localparam logic [31:0] POLL_ADDR   = 32'h4005_0200;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout, rsp_poll;
  logic [31:0] rsp_rdata;
  logic        poll_en;
  logic [31:0] poll_addr, poll_data;

  always #5 PCLK = ~PCLK;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_PERIOD(POLL_PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_poll(rsp_poll),
    .poll_en(poll_en), .poll_addr(poll_addr), .poll_data(poll_data),
    .apb(apb)
  );

  typedef struct { logic [31:0] rdata; logic err; logic to; } exp_t;
  typedef struct { int waits; bit err; } plan_t;

  exp_t        cmd_exp[$];
  exp_t        poll_exp[$];
  plan_t       plan_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_issued = 0, n_cmd_rsp = 0, poll_seen = 0, last_poll_cyc = -1;
  bit gap_chk = 0, force_poll_err = 0, poll_rand_err = 0;
  int poll_max_wait = 0;
  logic [31:0] good_poll = '0;

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Content of the virtual slave at addresses never written.
  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    slv_mem[a] = d;
  endtask

  // Present a command, wait for its handshake, record plan and expectation.
  // Returns #1 after the accepting edge with cmd_valid still high.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input bit err);
    int budget = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready) begin
      @(negedge PCLK);
      budget++;
      if (budget > 300) begin
        fail_now("cmd_handshake_timeout");
        cmd_valid = 1'b0;
        return;
      end
    end
    plan_q.push_back('{waits, err});
    e.to    = (waits >= int'(TIMEOUT));
    e.err   = e.to || err;
    e.rdata = (wr || e.to) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    if (wr && !e.err) ref_mem[a] = d;
    cmd_exp.push_back(e);
    n_issued++;
    @(posedge PCLK);
    #1;
  endtask

  // APB slave model: each ACCESS cycle k answers ready once k reaches the planned waits.
  int    k = 0;
  plan_t cur = '{0, 0};
  bit    cur_poll = 0;
  logic [31:0] poll_val = '0;
  initial begin
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = '0;
    forever begin
      @(posedge PCLK);
      #1;
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = $urandom;
      if (PRESERN !== 1'b1) continue;
      if (apb.PSEL && !apb.PENABLE) begin
        k = 0;
        if (apb.PADDR == POLL_ADDR && !apb.PWRITE) begin
          cur_poll  = 1;
          cur.waits = $urandom_range(0, poll_max_wait);
          cur.err   = force_poll_err || (poll_rand_err && ($urandom_range(0, 3) == 0));
          poll_val  = $urandom;
        end else begin
          cur_poll = 0;
          if (plan_q.size() == 0) begin
            fail_now("unexpected_apb_transfer");
            cur = '{0, 0};
          end else begin
            cur = plan_q.pop_front();
          end
        end
      end else if (apb.PSEL && apb.PENABLE) begin
        if (k >= cur.waits) begin
          apb.PREADY  = 1'b1;
          apb.PSLVERR = cur.err;
          if (cur_poll) begin
            apb.PRDATA = poll_val;
            poll_exp.push_back('{poll_val, cur.err, 1'b0});
          end else if (apb.PWRITE) begin
            if (!cur.err) slv_mem[apb.PADDR] = apb.PWDATA;
          end else begin
            apb.PRDATA = slv_mem.exists(apb.PADDR) ? slv_mem[apb.PADDR] : dflt(apb.PADDR);
          end
        end
        k++;
      end
    end
  end

  // Scoreboard monitor: pops the matching queue on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESERN === 1'b1 && rsp_valid === 1'b1) begin
        if (rsp_poll) begin
          if (poll_exp.size() == 0) begin
            fail_now("poll_rsp_unexpected");
          end else begin
            e = poll_exp.pop_front();
            check("poll_rdata", rsp_rdata, e.rdata);
            check("poll_err", 32'(rsp_err), 32'(e.err));
            check("poll_timeout", 32'(rsp_timeout), 32'(e.to));
            if (!e.err) good_poll = e.rdata;
            check("poll_data", poll_data, good_poll);
          end
          if (gap_chk && last_poll_cyc >= 0) check("poll_gap", 32'(cyc - last_poll_cyc), POLL_PERIOD);
          last_poll_cyc = cyc;
          poll_seen++;
        end else begin
          if (cmd_exp.size() == 0) begin
            fail_now("cmd_rsp_unexpected");
          end else begin
            e = cmd_exp.pop_front();
            check("cmd_rdata", rsp_rdata, e.rdata);
            check("cmd_err", 32'(rsp_err), 32'(e.err));
            check("cmd_timeout", 32'(rsp_timeout), 32'(e.to));
          end
          n_cmd_rsp++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, polls0, cmds0, b;
    PRESERN   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    poll_en   = 1'b0;
    poll_addr = POLL_ADDR;
    repeat (3) @(negedge PCLK);

    // Reset state
    check("rst_psel", 32'(apb.PSEL), 0);
    check("rst_penable", 32'(apb.PENABLE), 0);
    check("rst_pwrite", 32'(apb.PWRITE), 0);
    check("rst_paddr", apb.PADDR, 0);
    check("rst_pwdata", apb.PWDATA, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_rsp_poll", 32'(rsp_poll), 0);
    check("rst_poll_data", poll_data, 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    PRESERN = 1'b1;
    @(negedge PCLK);
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // Zero-wait write: SETUP N+1, ACCESS N+2, response N+3, next accept N+4
    send_cmd(1'b1, 32'h4005_0000, 32'h1, 0, 1'b0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("wr_setup_psel", 32'(apb.PSEL), 1);
    check("wr_setup_penable", 32'(apb.PENABLE), 0);
    check("wr_paddr", apb.PADDR, 32'h4005_0000);
    check("wr_pwrite", 32'(apb.PWRITE), 1);
    @(negedge PCLK);
    check("wr_access_psel", 32'(apb.PSEL), 1);
    check("wr_access_penable", 32'(apb.PENABLE), 1);
    check("wr_pwdata", apb.PWDATA, 32'h1);
    check("wr_no_rsp_yet", 32'(rsp_valid), 0);
    @(negedge PCLK);
    check("wr_rsp_valid", 32'(rsp_valid), 1);
    check("wr_resp_psel", 32'(apb.PSEL), 0);
    check("wr_resp_cmd_ready", 32'(cmd_ready), 0);
    @(negedge PCLK);
    check("wr_next_ready", 32'(cmd_ready), 1);
    check("wr_rsp_pulse_end", 32'(rsp_valid), 0);

    // Read with three wait states: response at N+6
    preload(32'h4005_0100, 32'h1234);
    send_cmd(1'b0, 32'h4005_0100, 32'h0, 3, 1'b0);
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge PCLK);
      else @(negedge PCLK);
      if (i == 5) check("rd_rsp_early", 32'(rsp_valid), 0);
      if (rsp_valid) cnt++;
    end
    check("rd_rsp_at_n6", 32'(rsp_valid), 1);
    check("rd_rdata", rsp_rdata, 32'h1234);
    @(negedge PCLK);

    // Slave never ready: abort after TIMEOUT access cycles
    send_cmd(1'b0, 32'h4005_0008, 32'h0, 100, 1'b0);
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge PCLK);
      if (apb.PENABLE) cnt++;
    end
    check("to_access_cycles", 32'(cnt), TIMEOUT);
    check("to_rsp_valid", 32'(rsp_valid), 1);
    check("to_rsp_timeout", 32'(rsp_timeout), 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    @(negedge PCLK);

    // Poll reads, then an erroring poll must leave poll_data unchanged
    poll_max_wait = 0;
    poll_en = 1'b1;
    b = 0;
    while (poll_seen < 2 && b < 200) begin @(negedge PCLK); b++; end
    force_poll_err = 1'b1;
    while (poll_seen < 3 && b < 200) begin @(negedge PCLK); b++; end
    force_poll_err = 1'b0;
    check("poll_directed_count", 32'(poll_seen), 3);
    check("poll_err_keeps_data", poll_data, good_poll);
    poll_en = 1'b0;
    repeat (8) @(negedge PCLK);

    // Polls interleave with a continuous command stream at a fixed period
    polls0 = poll_seen;
    cmds0  = n_cmd_rsp;
    poll_rand_err = 1'b1;
    last_poll_cyc = -1;
    gap_chk = 1'b1;
    poll_en = 1'b1;
    for (int i = 0; i < 30; i++)
      send_cmd($urandom_range(0, 1) == 1, 32'h4005_0000 + 32'($urandom_range(0, 7)) * 4,
               $urandom, 0, $urandom_range(0, 5) == 0);
    gap_chk = 1'b0;
    cmd_valid = 1'b0;
    repeat (12) @(negedge PCLK);
    check("arb_cmds_served", 32'(n_cmd_rsp - cmds0), 30);
    check("arb_poll_rate_ok", 32'((poll_seen - polls0) >= 25 && (poll_seen - polls0) <= 35), 1);

    // Random traffic with wait states, slave errors, timeouts and polling
    poll_max_wait = 2;
    for (int i = 0; i < 80; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 3));
      send_cmd($urandom_range(0, 1) == 1, 32'h4005_0000 + 32'($urandom_range(0, 7)) * 4,
               $urandom, w, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge PCLK);
      end
    end
    cmd_valid = 1'b0;
    repeat (30) @(negedge PCLK);
    poll_en = 1'b0;
    repeat (20) @(negedge PCLK);
    check("drain_cmd_queue", 32'(cmd_exp.size()), 0);
    check("drain_poll_queue", 32'(poll_exp.size()), 0);
    check("all_cmds_answered", 32'(n_cmd_rsp), 32'(n_issued));

    // Reset in the middle of an ACCESS phase
    send_cmd(1'b0, 32'h4005_000C, 32'h0, 100, 1'b0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_penable", 32'(apb.PENABLE), 1);
    #2;
    PRESERN = 1'b0;
    #1;
    check("async_rst_psel", 32'(apb.PSEL), 0);
    check("async_rst_penable", 32'(apb.PENABLE), 0);
    check("async_rst_rsp_valid", 32'(rsp_valid), 0);
    check("async_rst_poll_data", poll_data, 0);
    cmd_exp.delete();
    plan_q.delete();
    poll_exp.delete();
    good_poll = '0;
    @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    check("post_rst_paddr", apb.PADDR, 0);

    // Traffic still works after the reset
    send_cmd(1'b1, 32'h4005_0010, 32'hA5A5_0F0F, 1, 1'b0);
    send_cmd(1'b0, 32'h4005_0010, 32'h0, 2, 1'b0);
    cmd_valid = 1'b0;
    repeat (15) @(negedge PCLK);
    check("final_cmd_queue", 32'(cmd_exp.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
